// File: rtl/npu_input_pkg.sv
// Shared constants and elaboration helpers for the NPU input stream adapter.
package npu_input_pkg;

    localparam int NPU_IN_W   = 32;
    localparam int NPU_OUT_W  = 16;
    localparam int NPU_CONF_W = 16;

    function automatic int npu_clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // The host word must split into a whole number of beats.
    function automatic bit npu_ratio_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w >= out_w) && ((in_w % out_w) == 0);
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous W x DEPTH FIFO with occupancy count; head word is visible combinationally.
module npu_sync_fifo
    import npu_input_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic [npu_clog2(DEPTH):0]  level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = npu_clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the pre-pop count, so a write while full is dropped
    // even if a pop happens in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/npu_input_stream_adapter.sv
// Host-word FIFO feeding a holding register that serialises words into framed narrow beats.
// Define NPU_INPUT_MSB_FIRST_EN to emit the most significant slice of each word first.
module npu_input_stream_adapter
    import npu_input_pkg::*;
#(
    parameter int IN_W   = NPU_IN_W,
    parameter int OUT_W  = NPU_OUT_W,
    parameter int DEPTH  = 16,
    parameter int CONF_W = NPU_CONF_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IN_W-1:0]            wr_data,
    output logic                       full,
    output logic                       overflow,
    output logic [npu_clog2(DEPTH):0]  level,
    input  logic                       conf_en,
    input  logic [CONF_W-1:0]          conf_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic                       empty
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int LANE_W = (RATIO > 1) ? npu_clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if (!npu_ratio_ok(IN_W, OUT_W)) begin : g_bad_ratio
        $error("IN_W must be an integer multiple of OUT_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [IN_W-1:0]              fifo_head;
    logic                         fifo_empty;
    logic                         pop;
    logic [IN_W-1:0]              hold_word;
    logic                         hold_vld;
    logic [LANE_W-1:0]            lane;
    logic                         xfer;
    logic                         last_lane;
    logic [RATIO-1:0][OUT_W-1:0]  lanes;

    logic [CONF_W-1:0]            frame_len;
    logic [CONF_W-1:0]            beat_cnt;
    logic [CONF_W-1:0]            pending_len;
    logic                         pend;
    logic                         last_beat;

    npu_sync_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .level   (level),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign xfer      = hold_vld && out_ready;
    assign last_lane = (lane == LAST_LANE);
    // Reload on the final lane's transfer so consecutive words stream without a bubble.
    assign pop       = !fifo_empty && (!hold_vld || (xfer && last_lane));
    assign empty     = fifo_empty && !hold_vld;
    assign out_valid = hold_vld;

    for (genvar l = 0; l < RATIO; l++) begin : g_lane
`ifdef NPU_INPUT_MSB_FIRST_EN
        assign lanes[l] = hold_word[(RATIO-1-l)*OUT_W +: OUT_W];
`else
        assign lanes[l] = hold_word[l*OUT_W +: OUT_W];
`endif
    end

    assign out_data  = lanes[lane];
    assign last_beat = (frame_len != '0) && (beat_cnt == frame_len - CONF_W'(1));
    assign out_last  = hold_vld && last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_word <= '0;
            hold_vld  <= 1'b0;
            lane      <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop) begin
                hold_word <= fifo_head;
                hold_vld  <= 1'b1;
            end else if (xfer && last_lane) begin
                hold_vld  <= 1'b0;
            end
            if (xfer) lane <= last_lane ? '0 : lane + 1'b1;
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // A new length only takes effect at a frame boundary, so a frame in flight keeps its size.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_len   <= '0;
            beat_cnt    <= '0;
            pending_len <= '0;
            pend        <= 1'b0;
        end else begin
            if (xfer) beat_cnt <= (last_beat || frame_len == '0) ? '0 : beat_cnt + 1'b1;
            if (pend && ((beat_cnt == '0 && !xfer) || (xfer && last_beat))) begin
                frame_len <= pending_len;
                pend      <= 1'b0;
            end
            if (conf_en) begin
                pending_len <= conf_data;
                pend        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_npu_input_stream_adapter.sv
// Directed and randomised-handshake checks for npu_input_stream_adapter at default parameters.
module tb_npu_input_stream_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        overflow;
    logic [4:0]  level;
    logic        conf_en = 1'b0;
    logic [15:0] conf_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        empty;

    int checks = 0;
    int errors = 0;

    npu_input_stream_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .overflow  (overflow),
        .level     (level),
        .conf_en   (conf_en),
        .conf_data (conf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] beat_of(input logic [31:0] w, input int l);
`ifdef NPU_INPUT_MSB_FIRST_EN
        return (l == 0) ? w[31:16] : w[15:0];
`else
        return (l == 0) ? w[15:0] : w[31:16];
`endif
    endfunction

    function automatic logic [31:0] ovf_word(input int i);
        return {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
    endfunction

    function automatic logic [31:0] fw(input int i);
        return {16'(2*i + 2), 16'(2*i + 1)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; wr_en = 1'b0; conf_en = 1'b0; out_ready = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic set_frame(input logic [15:0] n);
        conf_en = 1'b1; conf_data = n;
        step;
        conf_en = 1'b0;
        step;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, expected 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0000", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, expected 0", out_last); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, expected 1", empty); end
    endtask

    task automatic test_basic;
        logic [31:0] w;
        w = 32'hBBBBAAAA;
        do_reset;
        out_ready = 1'b1; wr_en = 1'b1; wr_data = w;
        step;
        wr_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency0: out_valid %b, expected 0", out_valid); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty0: got %b, expected 0", empty); end
        step;
        checks++; if (out_valid !== 1'b1 || out_data !== beat_of(w, 0)) begin
            errors++; $display("FAIL basic_beat0: valid %b data %h, expected 1 %h", out_valid, out_data, beat_of(w, 0)); end
        step;
        checks++; if (out_valid !== 1'b1 || out_data !== beat_of(w, 1)) begin
            errors++; $display("FAIL basic_beat1: valid %b data %h, expected 1 %h", out_valid, out_data, beat_of(w, 1)); end
        step;
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL basic_drained: valid %b empty %b, expected 0 1", out_valid, empty); end
    endtask

    // The holding register absorbs the first word, so 17 writes fill the FIFO.
    task automatic test_overflow;
        int nb;
        do_reset;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = ovf_word(i);
            step;
        end
        wr_en = 1'b0;
        checks++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_fill: level %0d full %b ovf %b, expected 16 1 0", level, full, overflow); end
        wr_en = 1'b1; wr_data = 32'hDEADBEEF;
        step;
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || level !== 5'd16) begin
            errors++; $display("FAIL ovf_drop: ovf %b level %0d, expected 1 16", overflow, level); end
        step;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        out_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 80 && nb < 34; c++) begin
            if (out_valid) begin
                checks++; if (out_data !== beat_of(ovf_word(nb / 2), nb % 2)) begin
                    errors++; $display("FAIL ovf_drain_beat%0d: got %h, expected %h", nb, out_data, beat_of(ovf_word(nb / 2), nb % 2)); end
                nb++;
            end
            step;
        end
        out_ready = 1'b0;
        checks++; if (nb != 34) begin errors++; $display("FAIL ovf_drain_count: got %0d beats, expected 34", nb); end
        checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_after_drain: empty %b ovf %b, expected 1 1", empty, overflow); end
        do_reset;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b, expected 0", overflow); end
    endtask

    task automatic test_frames;
        int nb;
        int gaps;
        do_reset;
        set_frame(16'd3);
        out_ready = 1'b1;
        nb = 0; gaps = 0;
        for (int c = 0; c < 20 && nb < 6; c++) begin
            wr_en = (c < 3); wr_data = fw(c);
            if (out_valid) begin
                checks++; if (out_data !== beat_of(fw(nb / 2), nb % 2) || out_last !== (nb == 2 || nb == 5)) begin
                    errors++; $display("FAIL frame3_beat%0d: data %h last %b, expected %h %b",
                                       nb, out_data, out_last, beat_of(fw(nb / 2), nb % 2), (nb == 2 || nb == 5)); end
                nb++;
            end else if (nb > 0) gaps++;
            step;
        end
        wr_en = 1'b0;
        checks++; if (nb != 6 || gaps != 0) begin errors++; $display("FAIL frame3_stream: beats %0d gaps %0d, expected 6 0", nb, gaps); end
    endtask

    // Runs on from test_frames with frame_len=3 at a frame boundary.
    task automatic test_reconf;
        int nb;
        out_ready = 1'b1;
        conf_data = 16'd5;
        nb = 0;
        for (int c = 0; c < 30 && nb < 8; c++) begin
            wr_en = (c < 4); wr_data = fw(c + 8);
            conf_en = 1'b0;
            if (out_valid) begin
                checks++; if (out_data !== beat_of(fw(nb / 2 + 8), nb % 2) || out_last !== (nb == 2 || nb == 7)) begin
                    errors++; $display("FAIL reconf_beat%0d: data %h last %b, expected %h %b",
                                       nb, out_data, out_last, beat_of(fw(nb / 2 + 8), nb % 2), (nb == 2 || nb == 7)); end
                conf_en = (nb == 1);
                nb++;
            end
            step;
        end
        wr_en = 1'b0; conf_en = 1'b0;
        checks++; if (nb != 8) begin errors++; $display("FAIL reconf_count: got %0d beats, expected 8", nb); end
    endtask

    task automatic test_random;
        logic [15:0] exp_q[$];
        logic [15:0] exp_d;
        logic [15:0] prev_data;
        logic        prev_last;
        logic        prev_stall;
        int          acc;
        int          nxfer;
        int          mbeat;
        do_reset;
        set_frame(16'd7);
        acc = 0; nxfer = 0; mbeat = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int c = 0; c < 3000 && nxfer < 200; c++) begin
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++; $display("FAIL rand_stall_c%0d: valid %b data %h last %b, expected 1 %h %b",
                                       c, out_valid, out_data, out_last, prev_data, prev_last); end
            end
            out_ready = 1'($urandom_range(0, 1));
            wr_en = (acc < 100) && !full && ($urandom_range(0, 3) != 0);
            wr_data = $urandom;
            if (wr_en) begin
                exp_q.push_back(beat_of(wr_data, 0));
                exp_q.push_back(beat_of(wr_data, 1));
                acc++;
            end
            if (out_valid && out_ready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (out_data !== exp_d || out_last !== (mbeat == 6)) begin
                    errors++; $display("FAIL rand_beat%0d: data %h last %b, expected %h %b",
                                       nxfer, out_data, out_last, exp_d, (mbeat == 6)); end
                mbeat = (mbeat == 6) ? 0 : mbeat + 1;
                nxfer++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            step;
        end
        wr_en = 1'b0; out_ready = 1'b0;
        checks++; if (nxfer != 200 || overflow !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL rand_end: beats %0d ovf %b empty %b, expected 200 0 1", nxfer, overflow, empty); end
    endtask

    task automatic test_reset_mid;
        int nb;
        do_reset;
        set_frame(16'd3);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = fw(i + 20);
            step;
        end
        wr_en = 1'b0; out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        checks++; if (level !== 5'd4 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_prefill: level %0d valid %b, expected 4 1", level, out_valid); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if (level !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL mid_reset: level %0d empty %b valid %b ovf %b last %b, expected 0 1 0 0 0",
                               level, empty, out_valid, overflow, out_last); end
        out_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            wr_en = (c < 2); wr_data = fw(c + 30);
            if (out_valid) begin
                checks++; if (out_data !== beat_of(fw(nb / 2 + 30), nb % 2) || out_last !== 1'b0) begin
                    errors++; $display("FAIL mid_post_beat%0d: data %h last %b, expected %h 0",
                                       nb, out_data, out_last, beat_of(fw(nb / 2 + 30), nb % 2)); end
                nb++;
            end
            step;
        end
        wr_en = 1'b0;
        checks++; if (nb != 4 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_post_count: beats %0d empty %b, expected 4 1", nb, empty); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_frames;
        test_reconf;
        test_random;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
